alu_operand_seq: RTL and testbench

Operand-fetch and writeback sequencer that sits directly upstream of the 4-bit combinational alu (in1, in2, sel -> out) and also consumes its result.
- Holds a small register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the ALU operands and selector from registers, captures the ALU output, and writes it back to the destination register.
- Forms the datapath core of the CPU.

---
 rtl/alu_operand_seq.sv | 133 +++++++++++++
 tb/tb_alu_operand_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq.sv
// Operand-fetch / writeback sequencer wrapped around a combinational ALU.
// One instruction at a time: IDLE -> READ -> EXEC -> WB, with R0 hardwired to zero.
module alu_operand_seq #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_use_imm,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [ADDR_W-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [DATA_W-1:0] imm_reg;
    logic              use_imm_reg;
    logic [DATA_W-1:0] alu_in1_reg, alu_in2_reg;
    logic [2:0]        alu_sel_reg;
    logic [ADDR_W-1:0] wb_rd_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   we;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic              accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        instr_ready = (state_reg == IDLE);
        busy        = (state_reg != IDLE);
        wb_valid    = (state_reg == WB);
    end

    assign accept = instr_valid && instr_ready;

    // Per-register write enables; entry 0 never enables, so R0 stays at its reset zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_we
        assign we[gi] = (gi != 0) && (state_reg == WB) && (wb_rd_reg == ADDR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst)        regs[i] <= '0;
            else if (we[i]) regs[i] <= wb_data_reg;
        end
    end

    assign rs1_val  = (rs1_reg  == '0) ? '0 : regs[rs1_reg];
    assign rs2_val  = (rs2_reg  == '0) ? '0 : regs[rs2_reg];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= '0;
            rd_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            imm_reg     <= '0;
            use_imm_reg <= 1'b0;
            alu_in1_reg <= '0;
            alu_in2_reg <= '0;
            alu_sel_reg <= '0;
            wb_rd_reg   <= '0;
            wb_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    op_reg      <= instr_op;
                    rd_reg      <= instr_rd;
                    rs1_reg     <= instr_rs1;
                    rs2_reg     <= instr_rs2;
                    imm_reg     <= instr_imm;
                    use_imm_reg <= instr_use_imm;
                end
                READ: begin
                    alu_in1_reg <= rs1_val;
                    alu_in2_reg <= use_imm_reg ? imm_reg : rs2_val;
                    alu_sel_reg <= op_reg;
                end
                // wb_rd/wb_data double as the result register and keep their value after WB
                EXEC: begin
                    wb_data_reg <= alu_out;
                    wb_rd_reg   <= rd_reg;
                end
                default: ;
            endcase
        end
    end

    assign alu_in1 = alu_in1_reg;
    assign alu_in2 = alu_in2_reg;
    assign alu_sel = alu_sel_reg;
    assign wb_rd   = wb_rd_reg;
    assign wb_data = wb_data_reg;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq: behavioural ALU, register model and
// a writeback scoreboard filled at issue time and drained on each wb_valid pulse.
module tb_alu_operand_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic [3:0] instr_imm;
    logic       instr_use_imm;
    logic [3:0] alu_in1, alu_in2;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [5:0] exp_q[$];
    int         hs_q[$];
    logic [3:0] model [4];

    alu_operand_seq dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm), .instr_use_imm(instr_use_imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Downstream ALU: sel 000 adds mod 16, anything else xors
    always_comb alu_out = (alu_sel == 3'b000) ? alu_in1 + alu_in2 : alu_in1 ^ alu_in2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        if (!rst && instr_valid && instr_ready) hs_q.push_back(cycle);
    end

    // Scoreboard drain on every writeback pulse
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) check_eq("wb_unexpected", 1, 0);
            else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check_eq("wb_rd", {30'd0, wb_rd}, {30'd0, e[5:4]});
                check_eq("wb_data", {28'd0, wb_data}, {28'd0, e[3:0]});
            end
        end
    end

    function automatic logic [3:0] model_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        return (op == 3'b000) ? a + b : a ^ b;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm);
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_imm = imm; instr_use_imm = use_imm; instr_valid = 1'b1;
    endtask

    // Computes the expected result from the model and records it; returns operands
    task automatic predict(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm,
                           output logic [3:0] a, output logic [3:0] b, output logic [3:0] r);
        a = model[rs1];
        b = use_imm ? imm : model[rs2];
        r = model_res(op, a, b);
        exp_q.push_back({rd, r});
        if (rd != 2'd0) model[rd] = r;
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm);
        logic [3:0] a, b, r, old;
        int n;
        @(negedge clk);
        drive(op, rd, rs1, rs2, imm, use_imm);
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        check_eq("ready_wait", {31'd0, instr_ready}, 1);
        old = model[rd];
        @(posedge clk);
        predict(op, rd, rs1, rs2, imm, use_imm, a, b, r);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check_eq("read_busy", {30'd0, busy, instr_ready}, 32'b10);
        @(negedge clk);
        check_eq("exec_in1", {28'd0, alu_in1}, {28'd0, a});
        check_eq("exec_in2", {28'd0, alu_in2}, {28'd0, b});
        check_eq("exec_sel", {29'd0, alu_sel}, {29'd0, op});
        check_eq("exec_nowb", {31'd0, wb_valid}, 0);
        @(negedge clk);
        check_eq("wb_pulse", {31'd0, wb_valid}, 1);
        dbg_addr = rd;
        #1 check_eq("dbg_before_e3", {28'd0, dbg_data}, {28'd0, old});
        @(negedge clk);
        check_eq("wb_drop", {31'd0, wb_valid}, 0);
        check_eq("idle_ready", {31'd0, instr_ready}, 1);
        check_eq("wb_hold", {28'd0, wb_data}, {28'd0, r});
        #1 check_eq("dbg_after_e3", {28'd0, dbg_data}, {28'd0, model[rd]});
    endtask

    initial begin
        logic [3:0] a, b, r;
        rst = 1'b1; instr_valid = 1'b0; dbg_addr = 2'd0;
        drive(3'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready_busy", {30'd0, instr_ready, busy}, 32'b10);
        check_eq("rst_alu", {21'd0, alu_in1, alu_in2, alu_sel}, 0);
        check_eq("rst_wb", {25'd0, wb_valid, wb_rd, wb_data}, 0);
        rst = 1'b0;

        // 1..4: immediate load, reg+reg, wrap with rs1 == rd, write to R0
        run(3'd0, 2'd1, 2'd0, 2'd0, 4'd4, 1'b1);
        run(3'd0, 2'd2, 2'd0, 2'd0, 4'd9, 1'b1);
        run(3'd0, 2'd3, 2'd1, 2'd2, 4'd0, 1'b0);
        run(3'd0, 2'd2, 2'd2, 2'd0, 4'd9, 1'b1);
        run(3'd0, 2'd0, 2'd1, 2'd0, 4'd3, 1'b1);
        dbg_addr = 2'd0;
        #1 check_eq("r0_zero", {28'd0, dbg_data}, 0);

        // 5: instr_valid held across two back-to-back instructions
        @(negedge clk);
        hs_q.delete();
        drive(3'd0, 2'd3, 2'd3, 2'd0, 4'd5, 1'b1);
        @(posedge clk);
        predict(3'd0, 2'd3, 2'd3, 2'd0, 4'd5, 1'b1, a, b, r);
        #1 drive(3'd0, 2'd1, 2'd3, 2'd2, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_busy", {30'd0, instr_ready, busy}, 32'b01);
        end
        @(negedge clk);
        check_eq("bp_ready", {31'd0, instr_ready}, 1);
        @(posedge clk);
        predict(3'd0, 2'd1, 2'd3, 2'd2, 4'd0, 1'b0, a, b, r);
        #1 instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("bp_hs_count", hs_q.size(), 2);
        if (hs_q.size() == 2) check_eq("bp_hs_gap", hs_q[1] - hs_q[0], 4);
        dbg_addr = 2'd1;
        #1 check_eq("bp_r1", {28'd0, dbg_data}, {28'd0, model[1]});

        // 6: reset during EXEC aborts the instruction
        run(3'd0, 2'd1, 2'd0, 2'd0, 4'd4, 1'b1);
        @(negedge clk);
        drive(3'd0, 2'd1, 2'd0, 2'd0, 4'd9, 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_in_exec", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 4'd0;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_nowb", {31'd0, wb_valid}, 0);
        end
        check_eq("abort_ready", {30'd0, instr_ready, busy}, 32'b10);
        check_eq("abort_alu", {21'd0, alu_in1, alu_in2, alu_sel}, 0);
        for (int i = 1; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 check_eq("abort_reg", {28'd0, dbg_data}, 0);
        end
        check_eq("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
